// File: rtl/mem_stage_hs.sv
// Memory pipeline stage: 1-cycle pass-through for ALU ops, valid/ready request plus response
// handshake for loads/stores. Define MEM_TIMEOUT_EN to add the bus-error watchdog.
module mem_stage_hs #(
    parameter int               DATA_W         = 32,
    parameter int               TGT_W          = 5,
    parameter int               EXC_W          = 8,
    parameter int               TIMEOUT_CYCLES = 255,
    parameter logic [EXC_W-1:0] BUS_ERR_EXC    = EXC_W'(8'h0B)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                halt,
    input  logic                flush,
    input  logic                bubble_in,
    input  logic [TGT_W-1:0]    tgt_in,
    input  logic [DATA_W-1:0]   result_in,
    input  logic [DATA_W-1:0]   addr_in,
    input  logic [EXC_W-1:0]    exc_in,
    input  logic                mem_re_in,
    input  logic [DATA_W/8-1:0] mem_we_in,
    input  logic [DATA_W-1:0]   store_data_in,
    output logic                bubble_out,
    output logic [TGT_W-1:0]    tgt_out,
    output logic [DATA_W-1:0]   result_out,
    output logic [DATA_W-1:0]   addr_out,
    output logic [EXC_W-1:0]    exc_out,
    output logic                stall_out,
    output logic                mreq_valid,
    input  logic                mreq_ready,
    output logic [DATA_W-1:0]   mreq_addr,
    output logic [DATA_W/8-1:0] mreq_we,
    output logic [DATA_W-1:0]   mreq_wdata,
    input  logic                mresp_valid,
    input  logic [DATA_W-1:0]   mresp_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t            state;
    logic [TGT_W-1:0]  hold_tgt;
    logic [DATA_W-1:0] hold_result;
    logic              hold_store;
    logic              is_mem_op;

    // A zero bus-error code would be indistinguishable from "no exception".
    if (DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1 || BUS_ERR_EXC == '0) begin : g_bad_cfg
        $error("mem_stage_hs: invalid parameter set");
    end

    assign is_mem_op = !bubble_in && (exc_in == '0) && (mem_re_in || (mem_we_in != '0));
    assign stall_out = (state != S_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bubble_out  <= 1'b1;
            tgt_out     <= '0;
            result_out  <= '0;
            addr_out    <= '0;
            exc_out     <= '0;
            mreq_valid  <= 1'b0;
            mreq_addr   <= '0;
            mreq_we     <= '0;
            mreq_wdata  <= '0;
            hold_tgt    <= '0;
            hold_result <= '0;
            hold_store  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (halt || flush || bubble_in || is_mem_op) begin
                        bubble_out <= 1'b1;
                        tgt_out    <= '0;
                        result_out <= '0;
                        addr_out   <= '0;
                        exc_out    <= '0;
                    end else begin
                        bubble_out <= 1'b0;
                        tgt_out    <= tgt_in;
                        result_out <= result_in;
                        addr_out   <= addr_in;
                        exc_out    <= exc_in;
                    end
                    if (!halt && !flush && is_mem_op) begin
                        hold_tgt    <= tgt_in;
                        hold_result <= result_in;
                        hold_store  <= (mem_we_in != '0);
                        mreq_addr   <= addr_in;
                        mreq_we     <= mem_we_in;
                        mreq_wdata  <= store_data_in;
                        mreq_valid  <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Once accepted, the response must still be absorbed even if flushed.
                    if (mreq_ready) begin
                        mreq_valid <= 1'b0;
                        state      <= flush ? S_DRAIN : S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end else if (flush) begin
                        mreq_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (mresp_valid) begin
                        bubble_out <= 1'b0;
                        tgt_out    <= hold_tgt;
                        result_out <= hold_store ? hold_result : mresp_data;
                        addr_out   <= mreq_addr;
                        exc_out    <= '0;
                        state      <= S_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        bubble_out <= 1'b0;
                        tgt_out    <= hold_tgt;
                        result_out <= '0;
                        addr_out   <= mreq_addr;
                        exc_out    <= BUS_ERR_EXC;
                        state      <= S_DRAIN;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    bubble_out <= 1'b1;
                    tgt_out    <= '0;
                    result_out <= '0;
                    addr_out   <= '0;
                    exc_out    <= '0;
                    if (mresp_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
